// File: rtl/cfs_algn_pkg.sv
// Shared width helpers, field positions and legality check for the
// {size, offset, data} packed MD packet used by the aligner blocks.
package cfs_algn_pkg;

    // Which kind of output load happens in a given cycle
    typedef enum logic [1:0] {
        LOAD_NONE  = 2'd0,
        LOAD_FULL  = 2'd1,
        LOAD_FLUSH = 2'd2
    } load_e;

    function automatic int algn_bytes(input int dw);
        return dw / 8;
    endfunction

    // A single-byte bus still carries a 1-bit (always zero) offset field
    function automatic int algn_off_w(input int dw);
        return (dw <= 8) ? 1 : $clog2(dw / 8);
    endfunction

    function automatic int algn_size_w(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic int algn_fifo_w(input int dw);
        return dw + algn_off_w(dw) + algn_size_w(dw);
    endfunction

    // Field positions inside the packed word, data in the LSBs
    function automatic int algn_data_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int algn_off_lsb(input int dw);
        return dw;
    endfunction

    function automatic int algn_off_msb(input int dw);
        return dw + algn_off_w(dw) - 1;
    endfunction

    function automatic int algn_size_lsb(input int dw);
        return dw + algn_off_w(dw);
    endfunction

    function automatic int algn_size_msb(input int dw);
        return algn_fifo_w(dw) - 1;
    endfunction

    // A size/offset pair is usable when it names at least one byte
    // and does not run past the end of the data word
    function automatic logic algn_legal(
        input int size,
        input int offset,
        input int bytes
    );
        return (size != 0) && (offset + size <= bytes);
    endfunction

endpackage

// File: rtl/cfs_algn_byte_buf.sv
// Two-word FIFO-ordered byte staging buffer (byte 0 is the oldest).
// Ports: append (app_en/size/offset/data), consume_n bytes from the head,
// cnt = bytes held, head = the oldest BYTES bytes packed LSB-first.
module cfs_algn_byte_buf
    import cfs_algn_pkg::*;
#(
    parameter int  BYTES = 4,
    localparam int SW    = $clog2(BYTES) + 1,
    localparam int OW    = (BYTES <= 1) ? 1 : $clog2(BYTES),
    localparam int CW    = SW + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               app_en,
    input  logic [SW-1:0]      app_size,
    input  logic [OW-1:0]      app_offset,
    input  logic [8*BYTES-1:0] app_data,
    input  logic [SW-1:0]      consume_n,
    output logic [CW-1:0]      cnt,
    output logic [8*BYTES-1:0] head
);

    logic [7:0]    buf_q [2*BYTES];
    logic [7:0]    buf_d [2*BYTES];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Consume and append in one step: survivors shift down by n, then
    // the appended bytes land right behind them. Constant indices only,
    // each output byte is a compare-select over all candidate sources.
    always_comb begin
        int rem;
        int n;
        int sz;
        int off;
        n   = int'(consume_n);
        rem = int'(cnt_q) - n;
        sz  = app_en ? int'(app_size) : 0;
        off = int'(app_offset);
        for (int i = 0; i < 2*BYTES; i++) begin
            buf_d[i] = 8'h00;
            for (int s = 0; s < 2*BYTES; s++) begin
                if (i < rem && s == i + n) begin
                    buf_d[i] = buf_q[s];
                end
            end
            for (int b = 0; b < BYTES; b++) begin
                if (i >= rem && (i - rem) < sz && b == off + i - rem) begin
                    buf_d[i] = app_data[8*b +: 8];
                end
            end
        end
        cnt_d = cnt_q - CW'(consume_n) + CW'(sz);
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < BYTES; i++) begin
            head[8*i +: 8] = buf_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            for (int i = 0; i < 2*BYTES; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cfs_algn_stream_ctrl.sv
// Aligner controller: re-packs unaligned RX packets into ctrl_size-byte
// packets at ctrl_offset for the TX FIFO, with partial flush, input
// packet rejection and illegal-config stall. Ports: pop_* (RX side),
// push_* (TX side), ctrl_* (config/flush), status_* (observability).
module cfs_algn_stream_ctrl
    import cfs_algn_pkg::*;
#(
    parameter int  ALGN_DATA_WIDTH = 32,
    parameter int  FLUSH_CNT_WIDTH = 8,
    localparam int BYTES           = algn_bytes(ALGN_DATA_WIDTH),
    localparam int OFFSET_WIDTH    = algn_off_w(ALGN_DATA_WIDTH),
    localparam int SIZE_WIDTH      = algn_size_w(ALGN_DATA_WIDTH),
    localparam int FIFO_WIDTH      = algn_fifo_w(ALGN_DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pop_valid,
    input  logic [FIFO_WIDTH-1:0]      pop_data,
    output logic                       pop_ready,
    output logic                       push_valid,
    output logic [FIFO_WIDTH-1:0]      push_data,
    input  logic                       push_ready,
    input  logic [OFFSET_WIDTH-1:0]    ctrl_offset,
    input  logic [SIZE_WIDTH-1:0]      ctrl_size,
    input  logic [FLUSH_CNT_WIDTH-1:0] ctrl_flush_timeout,
    input  logic                       ctrl_flush_req,
    output logic                       status_cfg_err,
    output logic                       status_drop,
    output logic                       status_flush,
    output logic [SIZE_WIDTH:0]        status_level
);

    localparam int LVL_W    = SIZE_WIDTH + 1;
    localparam int OFF_LSB  = algn_off_lsb(ALGN_DATA_WIDTH);
    localparam int SIZE_LSB = algn_size_lsb(ALGN_DATA_WIDTH);

    logic [SIZE_WIDTH-1:0]      p_size;
    logic [OFFSET_WIDTH-1:0]    p_off;
    logic [OFFSET_WIDTH-1:0]    c_off;
    logic [ALGN_DATA_WIDTH-1:0] p_data;
    logic                       pop_hs;
    logic                       pop_legal;
    logic                       cfg_legal;
    logic                       slot_free;
    logic                       timeout_hit;
    logic                       flush_cond;
    load_e                      load;
    logic [SIZE_WIDTH-1:0]      load_n;
    logic [ALGN_DATA_WIDTH-1:0] packed_data;
    logic [LVL_W-1:0]           cnt;
    logic [ALGN_DATA_WIDTH-1:0] head;

    logic                       push_valid_q, push_valid_d;
    logic [FIFO_WIDTH-1:0]      push_data_q, push_data_d;
    logic [FLUSH_CNT_WIDTH-1:0] idle_q, idle_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       drop_q, drop_d;
    logic                       flush_q, flush_d;
    logic                       cfg_err_q, cfg_err_d;

    // A one-byte bus has no meaningful offset
    assign p_size = pop_data[SIZE_LSB +: SIZE_WIDTH];
    assign p_off  = (BYTES == 1) ? '0 : pop_data[OFF_LSB +: OFFSET_WIDTH];
    assign c_off  = (BYTES == 1) ? '0 : ctrl_offset;
    assign p_data = pop_data[ALGN_DATA_WIDTH-1:0];

    assign pop_legal = algn_legal(int'(p_size), int'(p_off), BYTES);
    assign cfg_legal = algn_legal(int'(ctrl_size), int'(c_off), BYTES);

    // Registered-only: never depends on push_ready or pop_valid
    assign pop_ready = (cnt <= LVL_W'(BYTES));
    assign pop_hs    = pop_valid & pop_ready;
    assign slot_free = ~push_valid_q | push_ready;

    assign timeout_hit = (ctrl_flush_timeout != '0) &&
                         (idle_q == ctrl_flush_timeout);
    assign flush_cond  = timeout_hit | ctrl_flush_req | flush_pend_q;

    always_comb begin
        load   = LOAD_NONE;
        load_n = '0;
        if (slot_free && cfg_legal) begin
            if (cnt >= {1'b0, ctrl_size}) begin
                load   = LOAD_FULL;
                load_n = ctrl_size;
            end else if (cnt != '0 && flush_cond) begin
                load   = LOAD_FLUSH;
                load_n = cnt[SIZE_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        packed_data = '0;
        for (int o = 0; o < BYTES; o++) begin
            for (int i = 0; i < BYTES; i++) begin
                if (i < int'(load_n) && o == i + int'(c_off)) begin
                    packed_data[8*o +: 8] = head[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        push_valid_d = (load != LOAD_NONE) | (push_valid_q & ~push_ready);
        push_data_d  = push_data_q;
        if (load != LOAD_NONE) begin
            push_data_d = {load_n, c_off, packed_data};
        end

        idle_d = idle_q;
        if (pop_hs || cnt == '0) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
        end

        // A flush trigger that cannot be served now waits for the slot
        flush_pend_d = (cnt != '0) && (load == LOAD_NONE) &&
                       (flush_pend_q || ctrl_flush_req || timeout_hit);

        drop_d    = pop_hs & ~pop_legal;
        flush_d   = (load == LOAD_FLUSH);
        cfg_err_d = ~cfg_legal;
    end

    cfs_algn_byte_buf #(
        .BYTES (BYTES)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .app_en     (pop_hs & pop_legal),
        .app_size   (p_size),
        .app_offset (p_off),
        .app_data   (p_data),
        .consume_n  (load_n),
        .cnt        (cnt),
        .head       (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            drop_q       <= 1'b0;
            flush_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            drop_q       <= drop_d;
            flush_q      <= flush_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign push_valid     = push_valid_q;
    assign push_data      = push_data_q;
    assign status_drop    = drop_q;
    assign status_flush   = flush_q;
    assign status_cfg_err = cfg_err_q;
    assign status_level   = cnt;

endmodule

// File: doc/cfs_algn_stream_ctrl.md
Name: cfs_algn_stream_ctrl

Overview:
Second-generation aligner controller. It sits between the RX FIFO and the TX FIFO and takes unaligned MD packets in packed {size, offset, data} form. It re-packs their bytes into packets of ctrl_size bytes at ctrl_offset, using a 2-word byte staging buffer so that pop and push can proceed in the same cycle. It adds partial-packet flush (idle timeout or request), rejection of illegal input packets, and an illegal-configuration stall with status.

Parameters:
ALGN_DATA_WIDTH, 32, data width in bits; power of 2, 8..1024.
FLUSH_CNT_WIDTH, 8, width of the idle-timeout counter and of ctrl_flush_timeout.
(derived) BYTES = ALGN_DATA_WIDTH/8.
(derived) OFFSET_WIDTH = (ALGN_DATA_WIDTH<=8) ? 1 : clog2(BYTES).
(derived) SIZE_WIDTH = clog2(BYTES)+1.
(derived) FIFO_WIDTH = ALGN_DATA_WIDTH+OFFSET_WIDTH+SIZE_WIDTH.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
pop_valid  in  1  RX FIFO has a packet
pop_data  in  FIFO_WIDTH  {size, offset, data}, data in LSBs
pop_ready  out  1  block accepts a packet
push_valid  out  1  aligned packet available
push_data  out  FIFO_WIDTH  {size, offset, data}
push_ready  in  1  TX FIFO accepts
ctrl_offset  in  OFFSET_WIDTH  output byte offset, quasi-static
ctrl_size  in  SIZE_WIDTH  output byte count, quasi-static
ctrl_flush_timeout  in  FLUSH_CNT_WIDTH  idle cycles before partial flush; 0 disables
ctrl_flush_req  in  1  single-cycle pulse that forces a partial flush
status_cfg_err  out  1  current ctrl_size/ctrl_offset are illegal
status_drop  out  1  one-cycle pulse when an illegal input packet is dropped
status_flush  out  1  one-cycle pulse when a partial packet is loaded
status_level  out  SIZE_WIDTH+1  bytes in the staging buffer (0..2*BYTES)

Behaviour:
- Reset is asynchronous: reset_n is asynchronous, active-low; clock clk. In reset: push_valid=0, push_data=0, buffer count cnt=0, idle counter=0, all status outputs 0. pop_ready=1.
- Staging buffer: 2*BYTES bytes, FIFO-ordered; byte 0 is the oldest.
- pop_ready = (cnt <= BYTES). It is a pure function of registers, with no combinational path from push_ready or pop_valid.
- Pop handshake: pop_valid & pop_ready at a rising edge.
- Illegal input packet: size==0 or offset+size>BYTES. Such a packet is consumed, discarded, cnt is unchanged, and status_drop pulses for the next cycle.
- Legal input packet: data bytes [offset .. offset+size-1] are appended in ascending order.
- Output slot is free when push_valid==0, or when push_valid & push_ready in this cycle.
- Full load: slot free, cfg legal and cnt >= ctrl_size. push_data.data = buffer bytes[0..ctrl_size-1] << 8*ctrl_offset, other bytes 0; size=ctrl_size; offset=ctrl_offset; N=ctrl_size.
- Flush load: slot free, cfg legal, 0 < cnt < ctrl_size, and (idle_cnt == ctrl_flush_timeout != 0, or ctrl_flush_req). Same packing but size=cnt; N=cnt; status_flush pulses.
- Full load takes priority over flush. ctrl_flush_req with cnt==0 is ignored. A flush request arriving while the slot is busy is held pending until the slot frees or cnt==0.
- Simultaneous load and pop: new cnt = cnt - N + popsize. Popped bytes are appended after the remaining bytes, so the flushed bytes always precede the new ones.
- ctrl_size/ctrl_offset are sampled at load time only; a change affects the next packet.
- push_data and push_valid stay stable while push_valid & !push_ready. If no load occurs on a push handshake, push_valid goes to 0.
- Latency: pop handshake to push_valid high is 1 cycle when enough bytes are present. Back-to-back packets are sustained at 1 packet/cycle.
- idle_cnt clears on a pop handshake or when cnt==0, else increments, saturating at max. For a timeout T, the flush packet appears at the rising edge T+1 edges after the last pop edge.
- cfg legal = ctrl_size != 0 and ctrl_offset+ctrl_size <= BYTES. While illegal: status_cfg_err=1, no loads, pops continue until pop_ready drops.
- When ALGN_DATA_WIDTH=8, offset is always 0.
- Reset asserted mid-operation: buffered bytes are lost and all outputs return to reset values immediately.

Decomposition:
- Package cfs_algn_pkg: width helper functions, field MSB/LSB constants for {size, offset, data}, and a legality check function.
- Sub-module cfs_algn_byte_buf: the 2*BYTES byte buffer with append(size, offset, data), consume(N), cnt, and a head window output.

Test Plan:
1. W=32, ctrl 4/0. Pop {1,0,0x11}, {1,1,0x2200}, {2,2,0x44330000} -> one push {4,0,0x44332211}, 1 cycle after the last pop.
2. ctrl 2/2. Pop {4,0,0xDDCCBBAA}, push_ready=1 -> pushes 0xBBAA0000 then 0xDDCC0000 on consecutive cycles. pop_ready stays 1.
3. ctrl 1/3, push_ready=0 for 10 cycles, continuous 4-byte pops -> pop_ready drops once cnt>4 and push_data stays stable. After release, 8 pushes follow in byte order with no loss.
4. ctrl 4/0, timeout 5. Pop {3,1,0xCCBBAA00} then idle -> push {3,0,0x00CCBBAA} at the 6th edge after the pop, with status_flush pulsed.
5. Pop {3,2,x} -> status_drop pulse, status_level unchanged. Set ctrl_size=0 -> status_cfg_err=1 and no push.
6. Assert reset_n=0 with cnt=3 and push_valid=1 -> all outputs cleared asynchronously and pop_ready=1. After release, ctrl 4/0 with a 4-byte pop -> normal push.
